// File: rtl/event_packetizer.sv
// Packs column-arbiter grants into {timestamp, row, column, polarity} packets and
// queues them in a small FIFO with valid/ready output; overflow events are counted.
module event_packetizer #(
    parameter int COLS     = 4,
    parameter int y_width  = 2,
    parameter int x_width  = 2,
    parameter int TS_WIDTH = 16,
    parameter int DEPTH    = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  enable_i,
    input  logic [COLS-1:0]                       col_gnt_i,
    input  logic [y_width-1:0]                    yadd_i,
    input  logic [x_width-1:0]                    xadd_i,
    input  logic                                  polarity_i,
    input  logic                                  ready_i,
    output logic                                  valid_o,
    output logic [TS_WIDTH+x_width+y_width:0]     data_o,
    output logic                                  full_o,
    output logic [$clog2(DEPTH):0]                level_o,
    output logic [7:0]                            drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = TS_WIDTH + x_width + y_width + 1;
    localparam logic [AW:0]         PTR_ONE = 1;
    localparam logic [TS_WIDTH-1:0] TS_ONE  = 1;

    logic [TS_WIDTH-1:0] r_ts;
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [7:0]          r_drop_cnt;
    logic [DW-1:0]       r_mem [DEPTH];

    logic                w_event;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [DW-1:0]       w_packet;

    assign w_event  = enable_i && (|col_gnt_i);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Pop only depends on registered occupancy, so a fresh push can never fall through.
    assign w_pop    = !w_empty && ready_i;
    assign w_push   = w_event && (!w_full || w_pop);
    assign w_drop   = w_event && w_full && !w_pop;
    assign w_packet = {r_ts, xadd_i, yadd_i, polarity_i};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_ts <= enable_i ? (r_ts + TS_ONE) : '0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries
    // are live, so resetting the array would only cost flops and routing.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_packet;
        end
    end

    assign data_o     = r_mem[r_rd_ptr[AW-1:0]];
    assign valid_o    = !w_empty;
    assign full_o     = w_full;
    assign level_o    = r_wr_ptr - r_rd_ptr;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_event_packetizer.sv
// Directed bench for event_packetizer: the driver queues expected packets, and a
// negedge monitor compares each handshaked packet against the queue head.
module tb_event_packetizer;

    localparam int DW = 21;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          enable_i;
    logic [3:0]    col_gnt_i;
    logic [1:0]    yadd_i;
    logic [1:0]    xadd_i;
    logic          polarity_i;
    logic          ready_i;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          full_o;
    logic [2:0]    level_o;
    logic [7:0]    drop_cnt_o;

    int            total = 0;
    int            bad   = 0;
    logic [15:0]   m_ts;
    logic [DW-1:0] exp_q [$];

    event_packetizer dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .col_gnt_i  (col_gnt_i),
        .yadd_i     (yadd_i),
        .xadd_i     (xadd_i),
        .polarity_i (polarity_i),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .full_o     (full_o),
        .level_o    (level_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes on the following posedge.
    always @(negedge clk_i) begin
        if (!reset_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pkt_unexpected: got %0h expected no packet", data_o);
            end else begin
                check("pkt", {11'd0, data_o}, {11'd0, exp_q.pop_front()});
            end
        end
    end

    // One clock; the timestamp model follows the enable level seen at the edge.
    task automatic step();
        @(posedge clk_i);
        m_ts = enable_i ? m_ts + 16'd1 : 16'd0;
        #1;
    endtask

    // One event cycle; acc says whether this event should be queued.
    task automatic ev(input logic [1:0] x, input logic [1:0] y, input logic p, input bit acc);
        col_gnt_i  = 4'b0100;
        xadd_i     = x;
        yadd_i     = y;
        polarity_i = p;
        if (acc) exp_q.push_back({m_ts, x, y, p});
        step();
        col_gnt_i = 4'b0000;
    endtask

    task automatic drain(input int n);
        ready_i = 1'b1;
        repeat (n) step();
        ready_i = 1'b0;
    endtask

    initial begin
        reset_i    = 1'b1;
        enable_i   = 1'b0;
        col_gnt_i  = 4'b0000;
        yadd_i     = 2'd0;
        xadd_i     = 2'd0;
        polarity_i = 1'b0;
        ready_i    = 1'b0;
        m_ts       = 16'd0;
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_level", {29'd0, level_o}, 32'd0);
        check("rst_full",  {31'd0, full_o}, 32'd0);
        check("rst_drop",  {24'd0, drop_cnt_o}, 32'd0);

        // Basic capture: event in cycle 3 carries timestamp 3.
        @(posedge clk_i); #1;
        reset_i  = 1'b0;
        enable_i = 1'b1;
        m_ts     = 16'd0;
        repeat (3) step();
        ev(2'd1, 2'd2, 1'b1, 1'b1);
        check("first_valid", {31'd0, valid_o}, 32'd1);
        check("first_data",  {11'd0, data_o}, 32'd109);
        check("first_level", {29'd0, level_o}, 32'd1);
        drain(1);
        check("drain1_level", {29'd0, level_o}, 32'd0);

        // Overflow: five events, four stored, one dropped.
        for (int i = 0; i < 5; i++) ev(2'(i), 2'(3 - i), i[0], i < 4);
        check("ovf_full",  {31'd0, full_o}, 32'd1);
        check("ovf_level", {29'd0, level_o}, 32'd4);
        check("ovf_drop",  {24'd0, drop_cnt_o}, 32'd1);
        drain(4);
        check("ovf_empty", {29'd0, level_o}, 32'd0);
        check("ovf_nfull", {31'd0, full_o}, 32'd0);

        // Full with simultaneous pop and push: accepted, level holds at 4.
        for (int i = 0; i < 4; i++) ev(2'(i), 2'(i), 1'b0, 1'b1);
        ready_i = 1'b1;
        ev(2'd3, 2'd1, 1'b1, 1'b1);
        ready_i = 1'b0;
        check("pp_level", {29'd0, level_o}, 32'd4);
        check("pp_drop",  {24'd0, drop_cnt_o}, 32'd1);
        drain(4);
        check("pp_empty", {29'd0, level_o}, 32'd0);

        // Drop counter saturation.
        for (int i = 0; i < 300; i++) begin
            ev(2'(i), 2'(i >> 2), i[0], i < 4);
            if (i == 256) check("drop_254", {24'd0, drop_cnt_o}, 32'd254);
        end
        check("drop_sat", {24'd0, drop_cnt_o}, 32'd255);
        drain(4);
        check("sat_empty", {29'd0, level_o}, 32'd0);

        // Enable low: no pushes, queue keeps draining, timestamp restarts.
        ev(2'd0, 2'd1, 1'b0, 1'b1);
        ev(2'd2, 2'd3, 1'b1, 1'b1);
        enable_i = 1'b0;
        ev(2'd1, 2'd1, 1'b1, 1'b0);
        check("dis_level", {29'd0, level_o}, 32'd2);
        drain(2);
        check("dis_empty", {29'd0, level_o}, 32'd0);
        enable_i = 1'b1;
        repeat (2) step();
        ev(2'd3, 2'd0, 1'b0, 1'b1);
        check("ts_restart", {11'd0, data_o}, {11'd0, 16'd2, 2'd3, 2'd0, 1'b0});

        // Asynchronous reset mid-cycle with three entries queued.
        ev(2'd1, 2'd1, 1'b1, 1'b1);
        ev(2'd2, 2'd2, 1'b0, 1'b1);
        check("pre_rst_level", {29'd0, level_o}, 32'd3);
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_valid", {31'd0, valid_o}, 32'd0);
        check("arst_level", {29'd0, level_o}, 32'd0);
        check("arst_drop",  {24'd0, drop_cnt_o}, 32'd0);
        check("arst_full",  {31'd0, full_o}, 32'd0);
        exp_q.delete();
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        m_ts    = 16'd0;
        step();
        ev(2'd2, 2'd1, 1'b1, 1'b1);
        check("post_rst_data", {11'd0, data_o}, {11'd0, 16'd1, 2'd2, 2'd1, 1'b1});
        drain(1);

        // Bounded wait for the scoreboard to empty.
        ready_i = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        ready_i = 1'b0;
        check("sb_empty", exp_q.size(), 32'd0);
        check("end_level", {29'd0, level_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
